// File: rtl/fpga_pll_rst_ctrl.sv
// PLL reset / lock supervisor: pulses the PLL reset, waits for a stable lock, then
// releases the system reset request; retries on lock timeout and latches lock loss.
module fpga_pll_rst_ctrl #(
    parameter int SYNC_STAGES      = 2,
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_TIMEOUT_CYC = 200000,
    parameter int STABLE_CYC       = 1024,
    parameter int MAX_RETRY        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       status_clr,
    output logic       pll_rst_n,
    output logic       sys_rst_n,
    output logic       lock_lost,
    output logic       fail,
    output logic [7:0] retry_cnt
);

    localparam int CNT_MAX_A = (PLL_RST_CYC > LOCK_TIMEOUT_CYC) ? PLL_RST_CYC : LOCK_TIMEOUT_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYC) ? CNT_MAX_A : STABLE_CYC;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAIL      = 3'd4;

    logic [SYNC_STAGES-1:0] locked_sync;
    logic                   locked_s;
    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [7:0]             retry_nxt;
    logic                   lost_set;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Stage: pll_locked synchronizer into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_sync <= '0;
        end else begin
            locked_sync <= {locked_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = locked_sync[SYNC_STAGES-1];

    // Stage: sequencing decision. The WAIT_LOCK cycle that first sees lock already counts
    // as stable cycle one, so STABLE is entered with cnt=1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        retry_nxt = retry_cnt;
        lost_set  = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = (STABLE_CYC <= 1) ? ST_RUN : ST_STABLE;
                    cnt_nxt   = (STABLE_CYC <= 1) ? '0 : CNT_ONE;
                end else if (cnt == TO_LAST) begin
                    cnt_nxt = '0;
                    if ((MAX_RETRY != 0) && (32'(retry_cnt) == MAX_RETRY)) begin
                        state_nxt = ST_FAIL;
                    end else begin
                        state_nxt = ST_PLL_RST;
                        retry_nxt = sat_inc8(retry_cnt);
                    end
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STB_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                cnt_nxt = '0;
                if (!locked_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    lost_set  = 1'b1;
                end
            end
            ST_FAIL: begin
                cnt_nxt = '0;
            end
            default: begin
                state_nxt = ST_PLL_RST;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Stage: state and registered outputs, all decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_PLL_RST;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_rst_n <= 1'b0;
            sys_rst_n <= 1'b0;
            fail      <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            pll_rst_n <= (state_nxt != ST_PLL_RST);
            sys_rst_n <= (state_nxt == ST_RUN);
            fail      <= (state_nxt == ST_FAIL);
            if (lost_set) begin
                lock_lost <= 1'b1;
            end else if (status_clr) begin
                lock_lost <= 1'b0;
            end
        end
    end

endmodule
